// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-op and phase definitions for the multicycle controller.
package cpu_pkg;

    // Instruction opcodes
    localparam int OP_HLT = 0;
    localparam int OP_SKZ = 1;
    localparam int OP_ADD = 2;
    localparam int OP_AND = 3;
    localparam int OP_XOR = 4;
    localparam int OP_LDA = 5;
    localparam int OP_STO = 6;
    localparam int OP_JMP = 7;

    // ALU operation encodings driven on alu_op
    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_XOR  = 2'b11;

    // Eight instruction phases, in execution order
    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

endpackage

// File: rtl/multicycle_controller_phase_counter.sv
// Phase/halt state: 3-bit wrapping phase counter with hold, halt entry,
// resume (load OP_FETCH) and asynchronous clear.
import cpu_pkg::*;

module phase_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,      // phase may advance this cycle
    input  logic       halt_set,  // HLT in OP_ADDR: enter halt instead of advancing
    input  logic       resume,    // leave halt, continue at OP_FETCH
    output logic [2:0] phase_q,
    output logic       halted_q
);

    // Halt exit ignores step/en; otherwise advance or park in halt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= 3'(INST_ADDR);
            halted_q <= 1'b0;
        end else if (halted_q) begin
            if (resume) begin
                halted_q <= 1'b0;
                phase_q  <= 3'(OP_FETCH);
            end
        end else if (step) begin
            if (halt_set)
                halted_q <= 1'b1;
            else
                phase_q <= phase_q + 3'd1;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// 8-phase instruction sequencer: decodes phase/opcode/zero into datapath
// strobes. Load/increment strobes are qualified by phase advance so a memory
// wait or en=0 never produces extra pulses.
import cpu_pkg::*;

module multicycle_controller #(
    parameter int OPCODE_W      = 3,
    parameter int ALUOP_W       = 2,
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                resume,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                sel,
    output logic                rd,
    output logic                wr,
    output logic                ld_ir,
    output logic                ld_ac,
    output logic                ld_pc,
    output logic                inc_pc,
    output logic                data_e,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                halted,
    output logic [2:0]          phase
);

    logic [2:0] phase_q;
    logic       halted_q;
    logic       is_hlt, is_skz, is_add, is_and, is_xor, is_lda, is_sto, is_jmp;
    logic       aluop_i;
    logic       wait_ph, mem_ok, step, halt_set;
    logic       ld_ir_raw, ld_ac_raw, ld_pc_raw, inc_pc_raw;

    // Full-width compares so wider unknown opcodes fall through as NOPs
    assign is_hlt  = (opcode == OPCODE_W'(OP_HLT));
    assign is_skz  = (opcode == OPCODE_W'(OP_SKZ));
    assign is_add  = (opcode == OPCODE_W'(OP_ADD));
    assign is_and  = (opcode == OPCODE_W'(OP_AND));
    assign is_xor  = (opcode == OPCODE_W'(OP_XOR));
    assign is_lda  = (opcode == OPCODE_W'(OP_LDA));
    assign is_sto  = (opcode == OPCODE_W'(OP_STO));
    assign is_jmp  = (opcode == OPCODE_W'(OP_JMP));
    assign aluop_i = is_add | is_and | is_xor | is_lda;

    // Memory-bound phases: instruction read, operand read, store write
    assign wait_ph  = (phase_q == 3'(INST_LOAD))
                    | ((phase_q == 3'(ALU_OP)) & aluop_i)
                    | ((phase_q == 3'(STORE))  & is_sto);
    assign mem_ok   = !USE_MEM_READY || mem_ready;
    assign step     = en & ~halted_q & (~wait_ph | mem_ok);
    // HLT still counts as a step so PC moves past the HLT before parking
    assign halt_set = (phase_q == 3'(OP_ADDR)) & is_hlt;

    phase_counter u_phase_counter (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .halt_set (halt_set),
        .resume   (resume),
        .phase_q  (phase_q),
        .halted_q (halted_q)
    );

    // Per-phase strobe decode; halted parks everything except sel
    always_comb begin
        sel        = 1'b0;
        rd         = 1'b0;
        wr         = 1'b0;
        data_e     = 1'b0;
        ld_ir_raw  = 1'b0;
        ld_ac_raw  = 1'b0;
        ld_pc_raw  = 1'b0;
        inc_pc_raw = 1'b0;
        if (halted_q) begin
            sel = 1'b1;
        end else begin
            case (phase_e'(phase_q))
                INST_ADDR:  sel = 1'b1;
                INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
                INST_LOAD,
                IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir_raw = 1'b1; end
                OP_ADDR:    inc_pc_raw = 1'b1;
                OP_FETCH:   rd = aluop_i;
                ALU_OP: begin
                    rd         = aluop_i;
                    inc_pc_raw = is_skz & zero;
                    ld_pc_raw  = is_jmp;
                    data_e     = is_sto;
                end
                STORE: begin
                    rd        = aluop_i;
                    ld_ac_raw = aluop_i;
                    ld_pc_raw = is_jmp;
                    wr        = is_sto;
                    data_e    = is_sto;
                end
                default: sel = 1'b1;
            endcase
        end
    end

    // ALU op tracks the opcode regardless of phase
    always_comb begin
        alu_op = ALUOP_W'(ALU_PASS);
        if (is_add) alu_op = ALUOP_W'(ALU_ADD);
        if (is_and) alu_op = ALUOP_W'(ALU_AND);
        if (is_xor) alu_op = ALUOP_W'(ALU_XOR);
    end

    assign ld_ir  = ld_ir_raw  & step;
    assign ld_ac  = ld_ac_raw  & step;
    assign ld_pc  = ld_pc_raw  & step;
    assign inc_pc = inc_pc_raw & step;
    assign halted = halted_q;
    assign phase  = phase_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller: stimulus pushes the
// hand-derived expected output vector each cycle, a negedge monitor compares.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       resume = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halted;
    logic [1:0] alu_op;
    logic [2:0] phase;

    multicycle_controller #(.OPCODE_W(3), .ALUOP_W(2), .USE_MEM_READY(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .resume(resume), .opcode(opcode),
        .zero(zero), .mem_ready(mem_ready), .sel(sel), .rd(rd), .wr(wr),
        .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc), .inc_pc(inc_pc),
        .data_e(data_e), .alu_op(alu_op), .halted(halted), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] exp;
        string       name;
    } item_t;

    item_t q[$];
    int    passed = 0;
    int    total  = 0;

    // Packing order: sel rd wr ld_ir ld_ac ld_pc inc_pc data_e alu_op halted phase
    function automatic logic [13:0] e(logic s, logic r, logic w, logic ir, logic ac,
                                      logic pc, logic inc, logic de, logic [1:0] alu,
                                      logic h, logic [2:0] ph);
        return {s, r, w, ir, ac, pc, inc, de, alu, h, ph};
    endfunction

    // Monitor: every cycle with an expectation pending, compare and count
    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            logic [13:0] act;
            it  = q.pop_front();
            act = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, alu_op, halted, phase};
            total++;
            if (act === it.exp) passed++;
            else $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
        end
    end

    // One cycle: drive inputs just after the edge, queue the expected outputs
    task automatic cyc(input logic r, input logic e_n, input logic res,
                       input logic [2:0] op, input logic z, input logic rdy,
                       input logic [13:0] ex, input string nm);
        @(posedge clk);
        #1;
        rst = r; en = e_n; resume = res; opcode = op; zero = z; mem_ready = rdy;
        q.push_back('{exp: ex, name: nm});
    endtask

    // Instruction fetch phases 0-3 with no waits
    task automatic fetch(input logic [2:0] op, input logic z, input logic [1:0] alu,
                         input string nm);
        cyc(0, 1, 0, op, z, 1, e(1,0,0,0,0,0,0,0, alu, 0, 3'd0), {nm, "_p0"});
        cyc(0, 1, 0, op, z, 1, e(1,1,0,0,0,0,0,0, alu, 0, 3'd1), {nm, "_p1"});
        cyc(0, 1, 0, op, z, 1, e(1,1,0,1,0,0,0,0, alu, 0, 3'd2), {nm, "_p2"});
        cyc(0, 1, 0, op, z, 1, e(1,1,0,1,0,0,0,0, alu, 0, 3'd3), {nm, "_p3"});
    endtask

    initial begin
        // Reset state
        cyc(1, 0, 0, 3'd0, 0, 1, e(1,0,0,0,0,0,0,0, 2'b00, 0, 3'd0), "reset");
        cyc(1, 1, 0, 3'd0, 0, 1, e(1,0,0,0,0,0,0,0, 2'b00, 0, 3'd0), "reset_en");

        // ADD, zero waits
        fetch(3'd2, 0, 2'b01, "add");
        cyc(0, 1, 0, 3'd2, 0, 1, e(0,0,0,0,0,0,1,0, 2'b01, 0, 3'd4), "add_p4");
        cyc(0, 1, 0, 3'd2, 0, 1, e(0,1,0,0,0,0,0,0, 2'b01, 0, 3'd5), "add_p5");
        cyc(0, 1, 0, 3'd2, 0, 1, e(0,1,0,0,0,0,0,0, 2'b01, 0, 3'd6), "add_p6");
        cyc(0, 1, 0, 3'd2, 0, 1, e(0,1,0,0,1,0,0,0, 2'b01, 0, 3'd7), "add_p7");

        // SKZ with zero=1: second increment in phase 6
        fetch(3'd1, 1, 2'b00, "skz1");
        cyc(0, 1, 0, 3'd1, 1, 1, e(0,0,0,0,0,0,1,0, 2'b00, 0, 3'd4), "skz1_p4");
        cyc(0, 1, 0, 3'd1, 1, 1, e(0,0,0,0,0,0,0,0, 2'b00, 0, 3'd5), "skz1_p5");
        cyc(0, 1, 0, 3'd1, 1, 1, e(0,0,0,0,0,0,1,0, 2'b00, 0, 3'd6), "skz1_p6");
        cyc(0, 1, 0, 3'd1, 1, 1, e(0,0,0,0,0,0,0,0, 2'b00, 0, 3'd7), "skz1_p7");

        // SKZ with zero=0: phase 4 increment only
        fetch(3'd1, 0, 2'b00, "skz0");
        cyc(0, 1, 0, 3'd1, 0, 1, e(0,0,0,0,0,0,1,0, 2'b00, 0, 3'd4), "skz0_p4");
        cyc(0, 1, 0, 3'd1, 0, 1, e(0,0,0,0,0,0,0,0, 2'b00, 0, 3'd5), "skz0_p5");
        cyc(0, 1, 0, 3'd1, 0, 1, e(0,0,0,0,0,0,0,0, 2'b00, 0, 3'd6), "skz0_p6");
        cyc(0, 1, 0, 3'd1, 0, 1, e(0,0,0,0,0,0,0,0, 2'b00, 0, 3'd7), "skz0_p7");

        // STO with three wait cycles in phase 7
        fetch(3'd6, 0, 2'b00, "sto");
        cyc(0, 1, 0, 3'd6, 0, 1, e(0,0,0,0,0,0,1,0, 2'b00, 0, 3'd4), "sto_p4");
        cyc(0, 1, 0, 3'd6, 0, 1, e(0,0,0,0,0,0,0,0, 2'b00, 0, 3'd5), "sto_p5");
        cyc(0, 1, 0, 3'd6, 0, 1, e(0,0,0,0,0,0,0,1, 2'b00, 0, 3'd6), "sto_p6");
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 0, 3'd6, 0, 0, e(0,0,1,0,0,0,0,1, 2'b00, 0, 3'd7), "sto_wait");
        cyc(0, 1, 0, 3'd6, 0, 1, e(0,0,1,0,0,0,0,1, 2'b00, 0, 3'd7), "sto_p7");

        // JMP with two wait cycles on the instruction read: no ld_ir while waiting
        cyc(0, 1, 0, 3'd7, 0, 1, e(1,0,0,0,0,0,0,0, 2'b00, 0, 3'd0), "jmp_p0");
        cyc(0, 1, 0, 3'd7, 0, 1, e(1,1,0,0,0,0,0,0, 2'b00, 0, 3'd1), "jmp_p1");
        cyc(0, 1, 0, 3'd7, 0, 0, e(1,1,0,0,0,0,0,0, 2'b00, 0, 3'd2), "jmp_wait2a");
        cyc(0, 1, 0, 3'd7, 0, 0, e(1,1,0,0,0,0,0,0, 2'b00, 0, 3'd2), "jmp_wait2b");
        cyc(0, 1, 0, 3'd7, 0, 1, e(1,1,0,1,0,0,0,0, 2'b00, 0, 3'd2), "jmp_p2");
        cyc(0, 1, 0, 3'd7, 0, 1, e(1,1,0,1,0,0,0,0, 2'b00, 0, 3'd3), "jmp_p3");
        cyc(0, 1, 0, 3'd7, 0, 1, e(0,0,0,0,0,0,1,0, 2'b00, 0, 3'd4), "jmp_p4");
        cyc(0, 1, 0, 3'd7, 0, 1, e(0,0,0,0,0,0,0,0, 2'b00, 0, 3'd5), "jmp_p5");
        cyc(0, 1, 0, 3'd7, 0, 1, e(0,0,0,0,0,1,0,0, 2'b00, 0, 3'd6), "jmp_p6");
        cyc(0, 1, 0, 3'd7, 0, 1, e(0,0,0,0,0,1,0,0, 2'b00, 0, 3'd7), "jmp_p7");

        // XOR: resume while running is ignored; one operand wait in phase 6
        fetch(3'd4, 0, 2'b11, "xor");
        cyc(0, 1, 0, 3'd4, 0, 1, e(0,0,0,0,0,0,1,0, 2'b11, 0, 3'd4), "xor_p4");
        cyc(0, 1, 1, 3'd4, 0, 1, e(0,1,0,0,0,0,0,0, 2'b11, 0, 3'd5), "xor_p5_resume");
        cyc(0, 1, 0, 3'd4, 0, 0, e(0,1,0,0,0,0,0,0, 2'b11, 0, 3'd6), "xor_wait6");
        cyc(0, 1, 0, 3'd4, 0, 1, e(0,1,0,0,0,0,0,0, 2'b11, 0, 3'd6), "xor_p6");
        cyc(0, 1, 0, 3'd4, 0, 1, e(0,1,0,0,1,0,0,0, 2'b11, 0, 3'd7), "xor_p7");

        // HLT: park at phase 4, resume with en=0, then finish the instruction
        fetch(3'd0, 0, 2'b00, "hlt");
        cyc(0, 1, 0, 3'd0, 0, 1, e(0,0,0,0,0,0,1,0, 2'b00, 0, 3'd4), "hlt_p4");
        for (int i = 0; i < 20; i++)
            cyc(0, 1, 0, 3'd0, 0, 1, e(1,0,0,0,0,0,0,0, 2'b00, 1, 3'd4), "hlt_parked");
        cyc(0, 0, 1, 3'd0, 0, 1, e(1,0,0,0,0,0,0,0, 2'b00, 1, 3'd4), "hlt_resume");
        cyc(0, 1, 0, 3'd0, 0, 1, e(0,0,0,0,0,0,0,0, 2'b00, 0, 3'd5), "hlt_p5");
        cyc(0, 1, 0, 3'd0, 0, 1, e(0,0,0,0,0,0,0,0, 2'b00, 0, 3'd6), "hlt_p6");
        cyc(0, 1, 0, 3'd0, 0, 1, e(0,0,0,0,0,0,0,0, 2'b00, 0, 3'd7), "hlt_p7");

        // STO with en=0 at phase 3, then async reset in phase 6
        cyc(0, 1, 0, 3'd6, 0, 1, e(1,0,0,0,0,0,0,0, 2'b00, 0, 3'd0), "enrst_p0");
        cyc(0, 1, 0, 3'd6, 0, 1, e(1,1,0,0,0,0,0,0, 2'b00, 0, 3'd1), "enrst_p1");
        cyc(0, 1, 0, 3'd6, 0, 1, e(1,1,0,1,0,0,0,0, 2'b00, 0, 3'd2), "enrst_p2");
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 0, 3'd6, 0, 1, e(1,1,0,0,0,0,0,0, 2'b00, 0, 3'd3), "en_hold");
        cyc(0, 1, 0, 3'd6, 0, 1, e(1,1,0,1,0,0,0,0, 2'b00, 0, 3'd3), "enrst_p3");
        cyc(0, 1, 0, 3'd6, 0, 1, e(0,0,0,0,0,0,1,0, 2'b00, 0, 3'd4), "enrst_p4");
        cyc(0, 1, 0, 3'd6, 0, 1, e(0,0,0,0,0,0,0,0, 2'b00, 0, 3'd5), "enrst_p5");
        cyc(1, 1, 0, 3'd6, 0, 1, e(1,0,0,0,0,0,0,0, 2'b00, 0, 3'd0), "async_rst");
        cyc(1, 1, 0, 3'd6, 0, 1, e(1,0,0,0,0,0,0,0, 2'b00, 0, 3'd0), "rst_held");
        cyc(0, 1, 0, 3'd6, 0, 1, e(1,0,0,0,0,0,0,0, 2'b00, 0, 3'd0), "post_rst_p0");
        cyc(0, 1, 0, 3'd6, 0, 1, e(1,1,0,0,0,0,0,0, 2'b00, 0, 3'd1), "post_rst_p1");

        // Drain the scoreboard, bounded
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d pending expectations, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
